// File: rtl/inst_mem_resp.sv
// Instruction fetch front end: one request in flight to a 1-cycle RAM, results land in a 2-entry in-order FIFO.
// Accept-to-resp_valid is 2 edges; req_ready drops once the FIFO plus in-flight slot hold two responses.
module inst_mem_resp #(
  parameter logic [63:0] PC_START = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  output logic        ram_en,
  output logic [63:0] ram_ridx,
  input  logic [63:0] ram_rdata
);

  logic        s1_vld_q, s1_vld_d;
  logic        s1_hi_q, s1_hi_d;
  logic        s1_err_q, s1_err_d;

  logic [31:0] ent_inst_q [2];
  logic [31:0] ent_inst_d [2];
  logic [1:0]  ent_err_q, ent_err_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        legal;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] push_inst;

  always_comb begin
    legal     = (req_addr[1:0] == 2'b00) && (req_addr >= PC_START);
    // Occupancy counts the in-flight slot so a response always has a FIFO entry waiting for it.
    req_ready = ({1'b0, count_q} + {2'b00, s1_vld_q}) < 3'd2;
    accept    = req_valid && req_ready && !rst;
    ram_en    = accept && legal;
    ram_ridx  = ram_en ? ((req_addr - PC_START) >> 3) : 64'h0;

    s1_vld_d  = accept;
    s1_hi_d   = req_addr[2];
    s1_err_d  = !legal;

    resp_valid = (count_q != 2'd0);
    resp_inst  = resp_valid ? ent_inst_q[rd_ptr_q] : 32'h0;
    resp_err   = resp_valid ? ent_err_q[rd_ptr_q] : 1'b0;

    push      = s1_vld_q;
    pop       = resp_valid && resp_ready;
    push_inst = s1_err_q ? 32'h0 : (s1_hi_q ? ram_rdata[63:32] : ram_rdata[31:0]);

    ent_inst_d = ent_inst_q;
    ent_err_d  = ent_err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      ent_inst_d[wr_ptr_q] = push_inst;
      ent_err_d[wr_ptr_q]  = s1_err_q;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q      <= 1'b0;
      s1_hi_q       <= 1'b0;
      s1_err_q      <= 1'b0;
      ent_inst_q[0] <= 32'h0;
      ent_inst_q[1] <= 32'h0;
      ent_err_q     <= 2'b00;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      s1_vld_q      <= s1_vld_d;
      s1_hi_q       <= s1_hi_d;
      s1_err_q      <= s1_err_d;
      ent_inst_q[0] <= ent_inst_d[0];
      ent_inst_q[1] <= ent_inst_d[1];
      ent_err_q     <= ent_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

endmodule
